// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller: cell and state encodings,
// the eight winning lines and a board cell accessor.
package ttt_pkg;

  localparam int unsigned NUM_CELLS = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1_TURN = 3'd1,
    P2_TURN = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] LINES [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic cell_t get_cell(input logic [17:0] board, input logic [3:0] idx);
    return cell_t'(board[{idx, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags each of the eight lines fully owned by the given player.
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  cell_t       player,
  output logic [7:0]  line_hit
);

  // One hit bit per line, set when all three of its cells equal the player.
  always_comb begin
    line_hit = 8'd0;
    for (int l = 0; l < 8; l++) begin
      line_hit[l] = (get_cell(board, LINES[l][0]) == player) &&
                    (get_cell(board, LINES[l][1]) == player) &&
                    (get_cell(board, LINES[l][2]) == player);
    end
  end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe game sequencer: shared cursor, board register, turn alternation, win/draw detection.
// Optional per-turn forfeit timer is enabled with the TURN_TIMEOUT_EN macro.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        p1_next,
  input  logic        p1_sel,
  input  logic        p2_next,
  input  logic        p2_sel,
  output logic [3:0]  cursor,
  output logic [17:0] board,
  output logic        turn,
  output logic        sel_err,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        timeout
);

  state_t      state_r, state_nx;
  logic [3:0]  cursor_r, cursor_nx;
  logic [17:0] board_r, board_nx;
  logic        turn_r, turn_nx;
  logic [3:0]  move_cnt_r, move_cnt_nx;
  cell_t       winner_r, winner_nx;
  logic        sel_err_r, sel_err_nx;
  logic        game_over_r;
  logic        timeout_nx;

  cell_t       mover_s;
  logic        active_next_s;
  logic        active_sel_s;
  logic        valid_sel_s;
  logic [7:0]  line_hit_s;

  assign mover_s       = turn_r ? P2 : P1;
  assign active_next_s = turn_r ? p2_next : p1_next;
  assign active_sel_s  = turn_r ? p2_sel : p1_sel;
  assign valid_sel_s   = active_sel_s && (get_cell(board_r, cursor_r) == EMPTY);

  ttt_win_check u_win_check (
    .board    (board_r),
    .player   (mover_s),
    .line_hit (line_hit_s)
  );

`ifdef TURN_TIMEOUT_EN
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] timer_r, timer_nx;
  logic        timeout_r;
`endif

  // Next-state, board, cursor and pulse computation.
  always_comb begin
    state_nx    = state_r;
    cursor_nx   = cursor_r;
    board_nx    = board_r;
    turn_nx     = turn_r;
    move_cnt_nx = move_cnt_r;
    winner_nx   = winner_r;
    sel_err_nx  = 1'b0;
    timeout_nx  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nx    = P1_TURN;
          cursor_nx   = 4'd0;
          board_nx    = 18'd0;
          turn_nx     = 1'b0;
          move_cnt_nx = 4'd0;
          winner_nx   = EMPTY;
        end else begin
          state_nx = state_r;
        end
      end
      P1_TURN, P2_TURN: begin
        // A sel always shadows a simultaneous next, even when the sel is rejected.
        if (active_sel_s) begin
          if (valid_sel_s) begin
            board_nx[{cursor_r, 1'b0} +: 2] = mover_s;
            move_cnt_nx = move_cnt_r + 4'd1;
            state_nx    = CHECK;
          end else begin
            sel_err_nx = 1'b1;
          end
        end else if (active_next_s) begin
          cursor_nx = (cursor_r == 4'd8) ? 4'd0 : cursor_r + 4'd1;
        end else begin
          cursor_nx = cursor_r;
        end
`ifdef TURN_TIMEOUT_EN
        if (!valid_sel_s && (timer_r == TIMER_LAST)) begin
          timeout_nx = 1'b1;
          turn_nx    = ~turn_r;
          state_nx   = turn_r ? P1_TURN : P2_TURN;
        end else begin
          timeout_nx = 1'b0;
        end
`endif
      end
      CHECK: begin
        if (|line_hit_s) begin
          state_nx  = DONE;
          winner_nx = mover_s;
        end else if (move_cnt_r == 4'd9) begin
          state_nx  = DONE;
          winner_nx = EMPTY;
        end else begin
          turn_nx  = ~turn_r;
          state_nx = turn_r ? P1_TURN : P2_TURN;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cursor_r    <= 4'd0;
      board_r     <= 18'd0;
      turn_r      <= 1'b0;
      move_cnt_r  <= 4'd0;
      winner_r    <= EMPTY;
      sel_err_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cursor_r    <= cursor_nx;
      board_r     <= board_nx;
      turn_r      <= turn_nx;
      move_cnt_r  <= move_cnt_nx;
      winner_r    <= winner_nx;
      sel_err_r   <= sel_err_nx;
      game_over_r <= (state_nx == DONE);
    end
  end

`ifdef TURN_TIMEOUT_EN
  // Turn timer restarts whenever a player's turn begins and runs while that turn lasts.
  always_comb begin
    timer_nx = 32'd0;
    if (((state_nx == P1_TURN) || (state_nx == P2_TURN)) && (state_nx != state_r)) begin
      timer_nx = 32'd0;
    end else if ((state_r == P1_TURN) || (state_r == P2_TURN)) begin
      timer_nx = timer_r + 32'd1;
    end else begin
      timer_nx = 32'd0;
    end
  end

  // Timer and forfeit pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r   <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      timer_r   <= timer_nx;
      timeout_r <= timeout_nx;
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign cursor    = cursor_r;
  assign board     = board_r;
  assign turn      = turn_r;
  assign sel_err   = sel_err_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed self-checking bench for ttt_turn_controller; the forfeit scenario runs only with TURN_TIMEOUT_EN.
module tb_ttt_turn_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        p1_next = 1'b0, p1_sel = 1'b0, p2_next = 1'b0, p2_sel = 1'b0;
  logic [3:0]  cursor;
  logic [17:0] board;
  logic        turn, sel_err, game_over, timeout;
  logic [1:0]  winner;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  ttt_turn_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_next(p1_next), .p1_sel(p1_sel), .p2_next(p2_next), .p2_sel(p2_sel),
    .cursor(cursor), .board(board), .turn(turn), .sel_err(sel_err),
    .game_over(game_over), .winner(winner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int who, input bit s, input bit n);
    if (who == 1) begin
      p1_sel = s; p1_next = n;
    end else begin
      p2_sel = s; p2_next = n;
    end
    tick();
    p1_sel = 1'b0; p1_next = 1'b0; p2_sel = 1'b0; p2_next = 1'b0;
  endtask

  task automatic adv(input int who, input int k);
    repeat (k) begin
      press(who, 1'b0, 1'b1);
      cur = (cur + 1) % 9;
    end
  endtask

  task automatic goto_cell(input int who, input int target);
    adv(who, (target - cur + 9) % 9);
  endtask

  task automatic play(input int who, input int target);
    goto_cell(who, target);
    press(who, 1'b1, 1'b0);
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cur = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_board", 32'(board), 32'd0);
    chk("rst_flags", {27'd0, turn, sel_err, game_over, timeout, 1'b0}, 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    rst = 1'b0;
    tick();

    // Three moves then an asynchronous reset mid-game.
    do_start();
    play(1, 0);
    play(2, 1);
    play(1, 2);
    chk("mid_board", 32'(board), 32'h19);
    chk("mid_turn", 32'(turn), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_board", 32'(board), 32'd0);
    chk("async_rst_cursor", 32'(cursor), 32'd0);
    chk("async_rst_turn_go", {30'd0, turn, game_over}, 32'd0);
    tick();
    rst = 1'b0;
    cur = 0;
    press(1, 1'b1, 1'b0);
    tick();
    chk("idle_ignores_sel", 32'(board), 32'd0);

    // Player 1 wins on the 0-4-8 diagonal.
    do_start();
    chk("start_turn", 32'(turn), 32'd0);
    play(1, 0);
    play(2, 3);
    goto_cell(1, 4);
    chk("cursor_at_4", 32'(cursor), 32'd4);
    press(1, 1'b1, 1'b0);
    tick();
    play(2, 5);
    goto_cell(1, 8);
    press(1, 1'b1, 1'b0);
    chk("win_not_yet", 32'(game_over), 32'd0);
    tick();
    chk("win_game_over", 32'(game_over), 32'd1);
    chk("win_winner", 32'(winner), 32'd1);
    chk("win_board", 32'(board), 32'h10981);
    press(1, 1'b0, 1'b1);
    chk("done_cursor_frozen", 32'(cursor), 32'd8);

    // Occupied cell rejection and inactive player ignored.
    do_start();
    chk("restart_board", 32'(board), 32'd0);
    chk("restart_go_win", {30'd0, game_over, winner != 2'b00}, 32'd0);
    play(1, 0);
    press(2, 1'b1, 1'b0);
    chk("sel_err_pulse", 32'(sel_err), 32'd1);
    chk("sel_err_board", 32'(board), 32'h1);
    chk("sel_err_turn", 32'(turn), 32'd1);
    tick();
    chk("sel_err_clear", 32'(sel_err), 32'd0);
    press(1, 1'b0, 1'b1);
    chk("p1_next_ignored", 32'(cursor), 32'd0);
    press(1, 1'b1, 1'b0);
    chk("p1_sel_ignored", {13'd0, sel_err, board}, 32'h1);

    // Sel beats a simultaneous next; cursor wraps 8 -> 0.
    goto_cell(2, 8);
    chk("cursor_at_8", 32'(cursor), 32'd8);
    press(2, 1'b1, 1'b1);
    chk("sel_next_board", 32'(board), 32'h20001);
    chk("sel_next_cursor", 32'(cursor), 32'd8);
    tick();
    chk("turn_back_p1", 32'(turn), 32'd0);
    adv(1, 1);
    chk("cursor_wrap", 32'(cursor), 32'd0);

    // Nine moves with no line: draw.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_start();
    play(1, 0); play(2, 1); play(1, 2); play(2, 4);
    play(1, 3); play(2, 5); play(1, 7); play(2, 6);
    chk("draw_pending", {30'd0, game_over, turn}, 32'd0);
    play(1, 8);
    chk("draw_game_over", 32'(game_over), 32'd1);
    chk("draw_winner", 32'(winner), 32'd0);
    chk("draw_board", 32'(board), 32'h16A59);
    chk("no_timeout_default", 32'(timeout), 32'd0);

`ifdef TURN_TIMEOUT_EN
    // Forfeit after 16 idle cycles, then a sel landing on the expiry cycle.
    do_start();
    repeat (15) tick();
    chk("to_before", {30'd0, timeout, turn}, 32'd0);
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_turn", 32'(turn), 32'd1);
    chk("to_board", 32'(board), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    repeat (14) tick();
    press(2, 1'b1, 1'b0);
    chk("to_sel_wins_board", 32'(board), 32'h2);
    chk("to_sel_wins_flag", 32'(timeout), 32'd0);
    tick();
    chk("to_sel_turn", 32'(turn), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
